// File: rtl/vote_rx_pkg.sv
// Shared definitions for the majority-vote serial receiver: FSM state
// encodings and the sample/decision offsets derived from the oversampling ratio.
package vote_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Three samples straddle mid-bit; the vote is taken one clock after the last.
    function automatic int samp0_off(input int osr);
        return osr / 2 - 1;
    endfunction

    function automatic int samp1_off(input int osr);
        return osr / 2;
    endfunction

    function automatic int samp2_off(input int osr);
        return osr / 2 + 1;
    endfunction

    function automatic int dec_off(input int osr);
        return osr / 2 + 2;
    endfunction

endpackage

// File: rtl/vote_rx_maj3.sv
// Combinational 3-input majority voter: output follows at least two inputs.
module maj3 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_f
);

    assign o_f = (i_a & i_b) | (i_b & i_c) | (i_a & i_c);

endmodule

// File: rtl/vote_rx.sv
// Oversampled 8N1-style receiver. Each bit is sampled three times around
// mid-bit and resolved by majority vote, so single-sample glitches are ignored.
module vote_rx
    import vote_rx_pkg::*;
#(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err
);

    localparam int CW = $clog2(OSR);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] C_S0   = CW'(samp0_off(OSR));
    localparam logic [CW-1:0] C_S1   = CW'(samp1_off(OSR));
    localparam logic [CW-1:0] C_S2   = CW'(samp2_off(OSR));
    localparam logic [CW-1:0] C_DEC  = CW'(dec_off(OSR));
    localparam logic [CW-1:0] C_LAST = CW'(OSR - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_s0;
    logic                 r_s1;
    logic                 r_s2;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_sr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;

    logic                 w_rxd_s;
    logic                 w_vote;
    logic [CW-1:0]        w_cnt_next;

    assign w_rxd_s    = r_sync2;
    assign w_cnt_next = (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;

    maj3 u_maj3 (
        .i_a (r_s0),
        .i_b (r_s1),
        .i_c (r_s2),
        .o_f (w_vote)
    );

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Capture the three mid-bit samples that feed the majority voter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else if (r_state != ST_IDLE) begin
            if (r_cnt == C_S0) r_s0 <= w_rxd_s;
            if (r_cnt == C_S1) r_s1 <= w_rxd_s;
            if (r_cnt == C_S2) r_s2 <= w_rxd_s;
        end
    end

    // Frame FSM with bit timing counters, shift register and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sr    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The falling edge itself counts as sample 0 of the start bit.
                    if (!w_rxd_s) begin
                        r_state <= ST_START;
                        r_cnt   <= CW'(1);
                    end
                end
                ST_START: begin
                    r_cnt <= w_cnt_next;
                    if (r_cnt == C_DEC && w_vote) begin
                        // Start bit did not hold low: treat as noise.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= ST_DATA;
                        r_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    r_cnt <= w_cnt_next;
                    if (r_cnt == C_DEC) begin
                        r_sr <= {w_vote, r_sr} >> 1;
                    end
                    if (r_cnt == C_LAST) begin
                        if (r_idx == I_LAST) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // Decide at the stop-bit vote and leave early so that a
                    // back-to-back start edge is never missed.
                    if (r_cnt == C_DEC) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        if (w_vote) begin
                            r_data  <= r_sr;
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
